// File: rtl/gsqrt_array.sv
// rtl/gsqrt_array.sv - multi-channel gain-based stochastic square-root array
// Define GSQRT_ARRAY_STATUS_EN to add sticky sat_hi/sat_lo saturation flags.
module gsqrt_array #(
   parameter int unsigned CH   = 4,
   parameter int unsigned CW   = 8,
   parameter int unsigned RW   = 6,
   parameter int unsigned DLY  = 1,
   parameter int unsigned INIT = 2**(CW-1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [CH-1:0]    en,
   input  logic             mode,
   input  logic [CH*RW-1:0] rand_num,
   input  logic [CH-1:0]    in,
   output logic [CH-1:0]    out
`ifdef GSQRT_ARRAY_STATUS_EN
   ,
   output logic [CH-1:0]    sat_hi,
   output logic [CH-1:0]    sat_lo
`endif
);

   if (DLY < 1 || DLY > 8) begin : g_bad_dly
      $error("gsqrt_array: DLY must be in 1..8");
   end
   if (RW > CW) begin : g_bad_rw
      $error("gsqrt_array: RW must not exceed CW");
   end

   localparam logic [CW-1:0] INIT_V = CW'(INIT);

   logic [CW-1:0]  cnt_q [CH];
   logic [CW-1:0]  cnt_d [CH];
   logic [DLY-1:0] dly_q [CH];
   logic [DLY-1:0] dly_d [CH];
   logic [CH-1:0]  out_dly;
   logic [CH-1:0]  dec;
   logic [CH-1:0]  up;
   logic [CH-1:0]  dn;
   logic [CH-1:0]  hit_hi;
   logic [CH-1:0]  hit_lo;

   always_comb begin
      out     = '0;
      out_dly = '0;
      dec     = '0;
      up      = '0;
      dn      = '0;
      hit_hi  = '0;
      hit_lo  = '0;
      for (int k = 0; k < CH; k++) begin
         cnt_d[k]   = cnt_q[k];
         dly_d[k]   = dly_q[k];
         out[k]     = cnt_q[k][CW-1 -: RW] > rand_num[k*RW +: RW];
         out_dly[k] = dly_q[k][DLY-1];
         dec[k]     = mode ? ~(out[k] ^ out_dly[k]) : (out[k] & out_dly[k]);
         up[k]      = en[k] & in[k] & ~dec[k];
         dn[k]      = en[k] & ~in[k] & dec[k];
         // Saturated attempts hold the counter; they only feed the status flags.
         hit_hi[k]  = up[k] & (cnt_q[k] == {CW{1'b1}});
         hit_lo[k]  = dn[k] & (cnt_q[k] == '0);
         if (up[k] && !hit_hi[k]) begin
            cnt_d[k] = cnt_q[k] + CW'(1);
         end else if (dn[k] && !hit_lo[k]) begin
            cnt_d[k] = cnt_q[k] - CW'(1);
         end
         if (en[k]) begin
            dly_d[k] = (dly_q[k] << 1) | DLY'(out[k]);
         end
         if (clr) begin
            cnt_d[k] = INIT_V;
            dly_d[k] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < CH; k++) begin
            cnt_q[k] <= INIT_V;
            dly_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < CH; k++) begin
            cnt_q[k] <= cnt_d[k];
            dly_q[k] <= dly_d[k];
         end
      end
   end

`ifdef GSQRT_ARRAY_STATUS_EN
   logic [CH-1:0] sat_hi_q;
   logic [CH-1:0] sat_hi_d;
   logic [CH-1:0] sat_lo_q;
   logic [CH-1:0] sat_lo_d;

   always_comb begin
      sat_hi_d = clr ? '0 : (sat_hi_q | hit_hi);
      sat_lo_d = clr ? '0 : (sat_lo_q | hit_lo);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_hi_q <= '0;
         sat_lo_q <= '0;
      end else begin
         sat_hi_q <= sat_hi_d;
         sat_lo_q <= sat_lo_d;
      end
   end

   assign sat_hi = sat_hi_q;
   assign sat_lo = sat_lo_q;
`endif

endmodule

// File: tb/tb_gsqrt_array.sv
// tb/tb_gsqrt_array.sv - randomized self-checking bench for gsqrt_array
// Drives a DLY=1 and a DLY=2 instance in parallel against a per-channel arithmetic model.
module tb_gsqrt_array;
   localparam int CH   = 4;
   localparam int CW   = 8;
   localparam int RW   = 6;
   localparam int INIT = 128;
   localparam int MAXC = 255;
   localparam int NI   = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr;
   logic             mode;
   logic [CH-1:0]    en;
   logic [CH-1:0]    in_b;
   logic [CH*RW-1:0] rand_num;
   logic [CH-1:0]    out_a;
   logic [CH-1:0]    out_b;
`ifdef GSQRT_ARRAY_STATUS_EN
   logic [CH-1:0]    hi_a, lo_a, hi_b, lo_b;
`endif

   always #5 clk = ~clk;

   gsqrt_array #(.CH(CH), .CW(CW), .RW(RW), .DLY(1), .INIT(INIT)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode),
      .rand_num(rand_num), .in(in_b), .out(out_a)
`ifdef GSQRT_ARRAY_STATUS_EN
      , .sat_hi(hi_a), .sat_lo(lo_a)
`endif
   );

   gsqrt_array #(.CH(CH), .CW(CW), .RW(RW), .DLY(2), .INIT(INIT)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode),
      .rand_num(rand_num), .in(in_b), .out(out_b)
`ifdef GSQRT_ARRAY_STATUS_EN
      , .sat_hi(hi_b), .sat_lo(lo_b)
`endif
   );

   int errors = 0;
   int checks = 0;
   int rn [CH];
   int m_cnt [NI][CH];
   bit m_hist [NI][CH][8];
   bit m_hi [NI][CH];
   bit m_lo [NI][CH];

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int dly_of(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic bit m_out(input int i, input int k);
      return (m_cnt[i][k] / 4) > rn[k];
   endfunction

   function automatic int obs_cnt(input int i, input int k);
      return (i == 0) ? int'(u_dut.cnt_q[k]) : int'(u_dut2.cnt_q[k]);
   endfunction

   function automatic int obs_out(input int i, input int k);
      return (i == 0) ? int'(out_a[k]) : int'(out_b[k]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NI; i++)
         for (int k = 0; k < CH; k++) begin
            m_cnt[i][k] = INIT;
            m_hi[i][k]  = 1'b0;
            m_lo[i][k]  = 1'b0;
            for (int j = 0; j < 8; j++) m_hist[i][k][j] = 1'b0;
         end
   endtask

   task automatic model_step();
      bit o, od, dec;
      if (clr) begin
         model_clear();
         return;
      end
      for (int i = 0; i < NI; i++)
         for (int k = 0; k < CH; k++) begin
            if (!en[k]) continue;
            o   = m_out(i, k);
            od  = m_hist[i][k][dly_of(i)-1];
            dec = mode ? (o == od) : (o && od);
            if (in_b[k] && !dec) begin
               if (m_cnt[i][k] == MAXC) m_hi[i][k] = 1'b1;
               else m_cnt[i][k]++;
            end else if (!in_b[k] && dec) begin
               if (m_cnt[i][k] == 0) m_lo[i][k] = 1'b1;
               else m_cnt[i][k]--;
            end
            for (int j = 7; j > 0; j--) m_hist[i][k][j] = m_hist[i][k][j-1];
            m_hist[i][k][0] = o;
         end
   endtask

   task automatic drive();
      for (int k = 0; k < CH; k++) rand_num[k*RW +: RW] = RW'(rn[k]);
   endtask

   task automatic chk_cnt(input string tag);
      for (int i = 0; i < NI; i++)
         for (int k = 0; k < CH; k++)
            chk($sformatf("%s_cnt_i%0d_ch%0d", tag, i, k), obs_cnt(i, k), m_cnt[i][k]);
   endtask

   // Entered just after a negedge; checks outputs, then advances one edge.
   task automatic cycle();
      drive();
      #1;
      for (int i = 0; i < NI; i++)
         for (int k = 0; k < CH; k++) begin
            chk($sformatf("out_i%0d_ch%0d", i, k), obs_out(i, k), int'(m_out(i, k)));
`ifdef GSQRT_ARRAY_STATUS_EN
            chk($sformatf("sat_hi_i%0d_ch%0d", i, k), (i == 0) ? int'(hi_a[k]) : int'(hi_b[k]), int'(m_hi[i][k]));
            chk($sformatf("sat_lo_i%0d_ch%0d", i, k), (i == 0) ? int'(lo_a[k]) : int'(lo_b[k]), int'(m_lo[i][k]));
`endif
         end
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   initial begin
      int n, ones;
      rst_n = 1'b0; clr = 1'b0; mode = 1'b0; en = '0; in_b = '0;
      for (int k = 0; k < CH; k++) rn[k] = 0;
      drive();
      model_clear();
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      chk_cnt("reset");

      // Threshold right at the reset value's top bits.
      rn[0] = 31; cycle();
      rn[0] = 32; cycle();

      // Count ch0 up to 180, then reset asynchronously mid-cycle.
      rn[0] = 63; in_b[0] = 1'b1; en[0] = 1'b1;
      n = 0;
      while (m_cnt[0][0] != 180 && n < 300) begin cycle(); n++; end
      chk("s6_reach180", m_cnt[0][0], 180);
      chk_cnt("s6_pre");
      rn[0] = 40; drive();
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      chk("s6_async_cnt_a", obs_cnt(0, 0), INIT);
      chk("s6_async_cnt_b", obs_cnt(1, 0), INIT);
      chk("s6_async_out", int'(out_a[0]), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk_cnt("s6_post");

      // Saturate ch0 high while ch1 drains towards its square-root floor.
      rn[0] = 63; rn[1] = 0; in_b[1] = 1'b0; en[1:0] = 2'b11; mode = 1'b0;
      for (int c = 0; c < 127; c++) cycle();
      chk("s2_cnt_at127", obs_cnt(0, 0), 255);
      for (int c = 0; c < 13; c++) cycle();
      chk("s2_cnt_hold", obs_cnt(0, 0), 255);
      chk("s3_and_floor_a", obs_cnt(0, 1), 3);
      chk("s3_and_floor_b", obs_cnt(1, 1), 3);
      mode = 1'b1;
      for (int c = 0; c < 10; c++) cycle();
      chk("s3_xnor_zero_a", obs_cnt(0, 1), 0);
      chk("s3_xnor_zero_b", obs_cnt(1, 1), 0);
      chk_cnt("s3_end");

      // Disabled channel holds, then count to 200 and clear.
      mode = 1'b0; en = 4'b1000; in_b = 4'b1000; rn[3] = 63;
      en[3] = 1'b0;
      for (int c = 0; c < 20; c++) cycle();
      chk("s5_hold", obs_cnt(0, 3), INIT);
      en[3] = 1'b1;
      n = 0;
      while (m_cnt[0][3] != 200 && n < 300) begin cycle(); n++; end
      chk("s5_reach200", obs_cnt(0, 3), 200);
      clr = 1'b1; cycle(); clr = 1'b0;
      chk("s5_clr_cnt", obs_cnt(1, 3), INIT);
      chk("s5_clr_dly", int'(u_dut2.dly_q[3]), 0);
      chk_cnt("s5_clr");

      // Stochastic square root: P(in)=0.25 should give P(out) close to 0.5.
      en = 4'b0100; in_b = '0; mode = 1'b0; ones = 0;
      for (int c = 0; c < 8192; c++) begin
         in_b[2] = ($urandom_range(0, 3) == 0);
         rn[2]   = $urandom_range(0, 63);
         drive();
         #1 ones += int'(out_b[2]);
         cycle();
      end
      chk("s4_mean_in_band", int'(ones >= 3768 && ones <= 4424), 1);
      chk_cnt("s4_end");

      // Fully random traffic including mode flips, enables and clears.
      for (int c = 0; c < 800; c++) begin
         en   = CH'($urandom);
         in_b = CH'($urandom);
         clr  = ($urandom_range(0, 63) == 0);
         if (c % 50 == 0) mode = 1'($urandom);
         for (int k = 0; k < CH; k++) rn[k] = $urandom_range(0, 63);
         cycle();
      end
      clr = 1'b0;
      chk_cnt("rand_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
